// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared types and constants for the pipeline stall/flush sequencer.
package pipeline_hazard_ctrl_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, DMEM_WAIT = 2'd1, MULDIV_WAIT = 2'd2} state_e;
  typedef struct packed {
    logic en;
    logic flush;
  } stage_ctrl_t;
  localparam logic [4:0] ZERO_REG = 5'd0;
  localparam stage_ctrl_t ADV = '{en: 1'b1, flush: 1'b0};
  localparam stage_ctrl_t HOLD = '{en: 1'b0, flush: 1'b0};
  localparam stage_ctrl_t BUBBLE = '{en: 1'b1, flush: 1'b1};
endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign cnt_d = (inc_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= clr_i ? '0 : cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: per-cycle advance/hold/bubble decisions for PC and the four pipeline registers.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_wr_addr,
  input  logic             ex_is_muldiv,
  input  logic             ex_redirect,
  input  logic             muldiv_done,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             muldiv_start,
  output logic [1:0]       busy_state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  state_e      state_q, state_d;
  logic        md_started_q, md_started_d;
  logic        dstall, mstall, lu, start, redirect_taken;
  stage_ctrl_t if_id, id_ex, ex_mem, mem_wb;
  assign dstall = dmem_req & ~dmem_ready;
  assign mstall = ex_is_muldiv & ~muldiv_done;
  assign lu = ex_mem_read & ex_reg_write & (ex_wr_addr != ZERO_REG) & id_valid &
              ((id_uses_rs1 & (id_rs1_addr == ex_wr_addr)) | (id_uses_rs2 & (id_rs2_addr == ex_wr_addr)));
  assign redirect_taken = ~rst & ~dstall & ~mstall & ex_redirect;
  // md_started survives a DMEM_WAIT detour so the same M-op is never started twice
  assign start = ~rst & (state_q == RUN) & ~dstall & ex_is_muldiv & ~md_started_q;
  assign md_started_d = muldiv_done ? 1'b0 : (md_started_q | start);
  assign state_d = dstall ? DMEM_WAIT : (state_q == DMEM_WAIT) ? RUN : mstall ? MULDIV_WAIT : RUN;
  always_comb begin
    pc_en = 1'b1;
    if_id = ADV;
    id_ex = ADV;
    ex_mem = ADV;
    mem_wb = ADV;
    if (rst) begin
      pc_en = 1'b0;
      if_id = BUBBLE;
      id_ex = BUBBLE;
      ex_mem = BUBBLE;
      mem_wb = BUBBLE;
    end else if (dstall) begin
      pc_en = 1'b0;
      if_id = HOLD;
      id_ex = HOLD;
      ex_mem = HOLD;
      mem_wb = BUBBLE;
    end else if (mstall) begin
      pc_en = 1'b0;
      if_id = HOLD;
      id_ex = HOLD;
      ex_mem = BUBBLE;
    end else if (ex_redirect) begin
      if_id = BUBBLE;
      id_ex = BUBBLE;
    end else if (lu) begin
      pc_en = 1'b0;
      if_id = HOLD;
      id_ex = BUBBLE;
    end else if (!imem_ready) begin
      pc_en = 1'b0;
      if_id = BUBBLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      md_started_q <= 1'b0;
    end else begin
      state_q <= state_d;
      md_started_q <= md_started_d;
    end
  end
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .clr_i(rst), .inc_i(~rst & ~pc_en), .cnt_o(stall_cycles)
  );
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .clr_i(rst), .inc_i(redirect_taken), .cnt_o(flush_count)
  );
  assign {if_id_en, if_id_flush} = if_id;
  assign {id_ex_en, id_ex_flush} = id_ex;
  assign {ex_mem_en, ex_mem_flush} = ex_mem;
  assign {mem_wb_en, mem_wb_flush} = mem_wb;
  assign muldiv_start = start;
  assign busy_state = state_q;
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32IM pipeline.
- Decides each cycle whether each of the four pipeline registers (IF_ID, ID_EX, EX_MEM, MEM_WB) and the PC advance, hold or take a bubble.
- Resolves load-use hazards, control redirects, instruction/data memory wait states and multi-cycle MUL/DIV handshakes.
- Keeps saturating stall/flush performance counters.

Parameters:
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  IF_ID holds a real instruction
- id_rs1_addr  in  5  rs1 of instruction in ID
- id_rs2_addr  in  5  rs2 of instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_mem_read  in  1  ID_EX.Mem_Read
- ex_reg_write  in  1  ID_EX.Reg_Write
- ex_wr_addr  in  5  ID_EX.Wr_Address
- ex_is_muldiv  in  1  EX holds a multi-cycle M-extension op
- ex_redirect  in  1  branch taken / JAL / JALR resolved in EX
- muldiv_done  in  1  M-unit result valid this cycle
- imem_ready  in  1  fetch data valid this cycle
- dmem_req  in  1  MEM stage issues load/store
- dmem_ready  in  1  data access completes this cycle
- pc_en  out  1  PC register load enable
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage register enable
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  load bubble (all control bits 0, Instruction_Started 0); only honoured when matching _en=1
- muldiv_start  out  1  single-cycle start pulse to M-unit
- busy_state  out  2  FSM state (RUN=0, DMEM_WAIT=1, MULDIV_WAIT=2)
- stall_cycles  out  CNT_W  cycles with pc_en=0
- flush_count  out  CNT_W  redirects taken

Behaviour:
- Clock and reset: one clock clk; rst synchronous active-high. While rst=1: all *_en=1, all *_flush=1, pc_en=0, muldiv_start=0, state RUN, counters 0.
- Conditions, evaluated combinationally each cycle:
  - dstall = dmem_req & ~dmem_ready
  - mstall = ex_is_muldiv & ~muldiv_done
  - lu = ex_mem_read & ex_reg_write & (ex_wr_addr!=0) & id_valid & ((id_uses_rs1 & rs1==ex_wr_addr) | (id_uses_rs2 & rs2==ex_wr_addr))
- Priority (highest first); default is all en=1, flush=0, pc_en=1.
  1. dstall: pc_en, if_id_en, id_ex_en, ex_mem_en = 0; mem_wb_flush=1.
  2. mstall: pc_en, if_id_en, id_ex_en = 0; ex_mem_flush=1; MEM/WB advance.
  3. ex_redirect: pc_en=1 (regardless of imem_ready), if_id_flush=1, id_ex_flush=1. Overrides lu (wrong-path) and imem stall. Fetch interface accepts the new PC and discards any in-flight fetch.
  4. lu: pc_en=0, if_id_en=0, id_ex_flush=1. Exactly one bubble per hazard (forwarding covers the rest).
  5. ~imem_ready: pc_en=0, if_id_flush=1; downstream advances.
- FSM:
  - RUN: dstall → DMEM_WAIT; else ex_is_muldiv & ~muldiv_done → MULDIV_WAIT, muldiv_start=1 this cycle only.
  - DMEM_WAIT: hold until dmem_ready, then → RUN. If EX holds an unstarted M-op, RUN issues its start on return. muldiv_start is never asserted in DMEM_WAIT.
  - MULDIV_WAIT: muldiv_start=0. On muldiv_done → RUN (EX advances the same cycle). dstall still takes priority and → DMEM_WAIT with an internal md_started flag kept set.
  - md_started clears on muldiv_done. It prevents a second start for the same instruction.
- An M-op with muldiv_done in its first EX cycle causes no stall. muldiv_start still pulses that cycle.
- Counters: stall_cycles += 1 when pc_en=0 & ~rst. flush_count += 1 when the redirect branch is taken. Both saturate at all-ones, no wrap.
- Reset mid-wait returns to RUN. The external M-unit and memory abort on rst.

Decomposition:
- Shared pipeline package gains:
  - state enum (RUN, DMEM_WAIT, MULDIV_WAIT)
  - stage_ctrl struct {en, flush}
  - ZERO_REG constant 5'd0
- One sub-module, sat_counter (CNT_W, inc, clr), instantiated twice.

Test Plan:
- Load x5 in EX, ID add x6,x5,x1 → one cycle pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all en=1; stall_cycles=1.
- Load x0 in EX, ID uses x0 → no stall.
- ex_redirect=1 with lu=1 and imem_ready=0 → pc_en=1, if_id_flush=1, id_ex_flush=1; flush_count=1.
- DIV in EX, muldiv_done after 4 cycles → muldiv_start high exactly 1 cycle, busy_state=2 for cycles 2-4, ex_mem_flush=1 each stalled cycle, EX advances on done.
- dmem_req=1, dmem_ready=0 for 3 cycles while DIV in EX → busy_state=1, mem_wb_flush=1, no muldiv_start; after ready, start pulses once.
- rst during MULDIV_WAIT → next cycle busy_state=0, counters 0, all flush=1 while rst high.
